// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: rebuilds VGA raster position from hsync/vsync, checks timing and blanking, captures a probe pixel
// Inputs: clk, reset (sync, active-high), hsync/vsync (active-low), red/green/blue, probe_x/probe_y
// Outputs: locked, x_pos/y_pos, active, frame_start, probe_rgb/probe_valid, h_err/v_err/blank_err, err_count
module vga_sync_monitor #(
  parameter int H_VIS       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_TOTAL     = 800,
  parameter int V_VIS       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic        locked,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        active,
  output logic        frame_start,
  output logic [11:0] probe_rgb,
  output logic        probe_valid,
  output logic        h_err,
  output logic        v_err,
  output logic        blank_err,
  output logic [7:0]  err_count
);
  localparam int HW = $clog2(H_TOTAL + 2);
  localparam int VW = $clog2(V_TOTAL * H_TOTAL + 2);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [9:0] X_VIS = 10'(H_VIS);
  localparam logic [9:0] Y_VIS = 10'(V_VIS);
  localparam logic [9:0] X_LOAD = 10'(H_VIS + H_FP);
  localparam logic [9:0] Y_LOAD = 10'(V_VIS + V_FP);
  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_PER = HW'(H_TOTAL);
  localparam logic [HW-1:0] H_LOW = HW'(H_SYNC);
  localparam logic [VW-1:0] V_PER = VW'(V_TOTAL * H_TOTAL);
  localparam logic [VW-1:0] V_LOW = VW'(V_SYNC * H_TOTAL);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);
  typedef enum logic [1:0] {SEARCH, ACQ, LOCKED} state_t;
  state_t state_q, state_d;
  logic hs_q, vs_q, vsf_q, h_seen_q, h_seen_d, v_seen_q, v_seen_d, ferr_q, ferr_d;
  logic hs_fall, hs_rise, vs_fall, vs_rise, x_wrap, lock_d, vis_d, err_any, enter_search;
  logic h_err_d, v_err_d, hit_d;
  logic [HW-1:0] hcnt_q;
  logic [VW-1:0] vcnt_q;
  logic [GW-1:0] good_q, good_d;
  logic [9:0] x_q, y_q, x_d, y_d;
  logic [11:0] rgb;
  assign rgb = {red, green, blue};
  // edges of the registered syncs, seen as the new sample arrives
  assign hs_fall = hs_q & ~hsync;
  assign hs_rise = ~hs_q & hsync;
  assign vs_fall = vs_q & ~vsync;
  assign vs_rise = ~vs_q & vsync;
  assign x_wrap = !hs_fall && x_q == X_LAST;
  assign x_d = hs_fall ? X_LOAD : x_wrap ? 10'd0 : x_q + 10'd1;
  assign y_d = vs_fall ? Y_LOAD : !x_wrap ? y_q : y_q == Y_LAST ? 10'd0 : y_q + 10'd1;
  // one counter per axis restarts at each fall: read at the rise it is the low run, at the next fall the period
  assign h_err_d = h_seen_q & ((hs_fall & (hcnt_q != H_PER)) | (hs_rise & (hcnt_q != H_LOW)));
  assign v_err_d = v_seen_q & ((vs_fall & (vcnt_q != V_PER)) | (vs_rise & (vcnt_q != V_LOW)));
  assign err_any = h_err | v_err;
  assign enter_search = state_q == LOCKED && state_d == SEARCH;
  assign h_seen_d = enter_search ? 1'b0 : hs_fall ? 1'b1 : h_seen_q;
  assign v_seen_d = enter_search ? 1'b0 : vs_fall ? 1'b1 : v_seen_q;
  assign lock_d = state_d == LOCKED;
  assign vis_d = x_d < X_VIS && y_d < Y_VIS;
  assign hit_d = lock_d && vis_d && x_d == probe_x && y_d == probe_y;
  assign locked = state_q == LOCKED;
  assign active = locked && x_q < X_VIS && y_q < Y_VIS;
  assign x_pos = x_q;
  assign y_pos = y_q;
  always_comb begin
    state_d = state_q;
    good_d = good_q;
    ferr_d = ferr_q;
    if (state_q == SEARCH) begin
      if (vsf_q) begin
        state_d = ACQ;
        good_d = '0;
        ferr_d = 1'b0;
      end
    end else if (state_q == ACQ) begin
      if (vsf_q) begin
        ferr_d = 1'b0;
        if (err_any || ferr_q) good_d = '0;
        else if (good_q == GOOD_LAST) state_d = LOCKED;
        else good_d = good_q + GW'(1);
      end else if (err_any) begin
        good_d = '0;
        ferr_d = 1'b1;
      end
    end else if (err_any) begin
      state_d = SEARCH;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEARCH;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      vsf_q <= 1'b0;
      h_seen_q <= 1'b0;
      v_seen_q <= 1'b0;
      ferr_q <= 1'b0;
      good_q <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      x_q <= '0;
      y_q <= '0;
      h_err <= 1'b0;
      v_err <= 1'b0;
      blank_err <= 1'b0;
      frame_start <= 1'b0;
      probe_valid <= 1'b0;
      probe_rgb <= '0;
      err_count <= '0;
    end else begin
      state_q <= state_d;
      hs_q <= hsync;
      vs_q <= vsync;
      vsf_q <= vs_fall;
      h_seen_q <= h_seen_d;
      v_seen_q <= v_seen_d;
      ferr_q <= ferr_d;
      good_q <= good_d;
      hcnt_q <= hs_fall ? HW'(1) : &hcnt_q ? hcnt_q : hcnt_q + HW'(1);
      vcnt_q <= vs_fall ? VW'(1) : &vcnt_q ? vcnt_q : vcnt_q + VW'(1);
      x_q <= x_d;
      y_q <= y_d;
      h_err <= h_err_d;
      v_err <= v_err_d;
      blank_err <= lock_d && !vis_d && rgb != 12'h0;
      frame_start <= lock_d && x_d == 10'd0 && y_d == 10'd0;
      probe_valid <= hit_d;
      if (hit_d) probe_rgb <= rgb;
      if ((h_err || v_err || blank_err) && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: scaled-raster stimulus checked per cycle against a timestamp-based model plus scenario tables
module tb_vga_sync_monitor;
  localparam int HV = 6, HF = 1, HS = 2, HT = 12, VV = 4, VF = 1, VS = 2, VT = 8, LF = 2;
  logic clk = 0, reset = 1, hsync = 1, vsync = 1;
  logic [3:0] red = 0, green = 0, blue = 0;
  logic [9:0] probe_x = '1, probe_y = '1;
  logic locked, active, frame_start, probe_valid, h_err, v_err, blank_err;
  logic [9:0] x_pos, y_pos;
  logic [11:0] probe_rgb;
  logic [7:0] err_count;
  always #5 clk = ~clk;
  vga_sync_monitor #(.H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_TOTAL(HT), .V_VIS(VV), .V_FP(VF),
    .V_SYNC(VS), .V_TOTAL(VT), .LOCK_FRAMES(LF)) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .probe_x(probe_x), .probe_y(probe_y), .locked(locked), .x_pos(x_pos), .y_pos(y_pos),
    .active(active), .frame_start(frame_start), .probe_rgb(probe_rgb), .probe_valid(probe_valid),
    .h_err(h_err), .v_err(v_err), .blank_err(blank_err), .err_count(err_count));
  int n_chk = 0, n_bad = 0;
  int gx = 0, gy = 0, gvt = VT, f_line = -1, f_hlen = HS, inj_x = -1, inj_y = -1;
  logic [11:0] inj_rgb = 0;
  bit rnd_vis = 0;
  int cyc = 0, m_hlast = 0, m_vlast = 0, m_state = 0, m_good = 0, m_x = 0, m_y = 0, m_cnt = 0;
  bit m_hq = 1, m_vq = 1, m_hseen, m_vseen, m_ferr, m_herr, m_verr, m_berr, m_vsf, m_fs, m_pv, m_act;
  logic [11:0] m_prgb = 0;
  int p_h, p_v, p_b, p_pv, p_lk;
  typedef struct {
    int fline, fhlen, ix, iy;
    logic [11:0] irgb;
    int vt, eh, ev, eb;
    bit lk1, lk2;
  } scen_t;
  scen_t tbl[7];
  task automatic chk(input string nm, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask
  // model: periods and low runs from absolute timestamps of the last sync falls
  task automatic model_step();
    bit hf, hr, vf, vr, he, ve, err, lk, wrap;
    int st, x, y;
    logic [11:0] rgb;
    rgb = {red, green, blue};
    cyc++;
    if (reset) begin
      m_hq = 1; m_vq = 1; m_x = 0; m_y = 0; m_hseen = 0; m_vseen = 0; m_state = 0; m_good = 0;
      m_ferr = 0; m_herr = 0; m_verr = 0; m_berr = 0; m_vsf = 0; m_fs = 0; m_pv = 0; m_act = 0;
      m_cnt = 0; m_prgb = 0;
      return;
    end
    hf = m_hq && !hsync; hr = !m_hq && hsync;
    vf = m_vq && !vsync; vr = !m_vq && vsync;
    he = m_hseen && ((hf && cyc - m_hlast != HT) || (hr && cyc - m_hlast != HS));
    ve = m_vseen && ((vf && cyc - m_vlast != VT * HT) || (vr && cyc - m_vlast != VS * HT));
    err = m_herr || m_verr;
    st = m_state;
    if (m_state == 0) begin
      if (m_vsf) begin st = 1; m_good = 0; m_ferr = 0; end
    end else if (m_state == 1) begin
      if (m_vsf) begin
        if (err || m_ferr) m_good = 0;
        else if (m_good + 1 >= LF) st = 2;
        else m_good++;
        m_ferr = 0;
      end else if (err) begin
        m_good = 0; m_ferr = 1;
      end
    end else if (err) st = 0;
    if (m_state == 2 && st == 0) begin m_hseen = 0; m_vseen = 0; end
    else begin if (hf) m_hseen = 1; if (vf) m_vseen = 1; end
    if (hf) m_hlast = cyc;
    if (vf) m_vlast = cyc;
    if (m_herr || m_verr || m_berr) m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
    wrap = !hf && m_x == HT - 1;
    x = hf ? HV + HF : (m_x + 1) % HT;
    y = vf ? VV + VF : wrap ? (m_y + 1) % VT : m_y;
    lk = st == 2;
    m_act = lk && x < HV && y < VV;
    m_berr = lk && !(x < HV && y < VV) && rgb != 0;
    m_fs = lk && x == 0 && y == 0;
    m_pv = m_act && x == probe_x && y == probe_y;
    if (m_pv) m_prgb = rgb;
    m_herr = he; m_verr = ve; m_vsf = vf; m_state = st; m_x = x; m_y = y; m_hq = hsync; m_vq = vsync;
  endtask
  task automatic step();
    int hl;
    logic [46:0] got, want;
    hl = (gy == f_line) ? f_hlen : HS;
    hsync = !(gx >= HV + HF && gx < HV + HF + hl);
    vsync = !(gy >= VV + VF && gy < VV + VF + VS);
    {red, green, blue} = (rnd_vis && gx < HV && gy < VV) ? 12'($urandom) : 12'h0;
    if (gx == inj_x && gy == inj_y) {red, green, blue} = inj_rgb;
    @(posedge clk);
    model_step();
    #1;
    want = {m_state == 2, 10'(m_x), 10'(m_y), m_act, m_fs, m_prgb, m_pv, m_herr, m_verr, m_berr, 8'(m_cnt)};
    got = {locked, x_pos, y_pos, active, frame_start, probe_rgb, probe_valid, h_err, v_err, blank_err, err_count};
    n_chk++;
    if (got !== want) begin
      n_bad++;
      if (n_bad <= 20) $display("FAIL cycle %0d outputs: got %h want %h", cyc, got, want);
    end
    p_h += int'(h_err); p_v += int'(v_err); p_b += int'(blank_err);
    p_pv += int'(probe_valid); p_lk += int'(locked);
    gx++;
    if (gx == HT) begin
      gx = 0; gy++;
      if (gy >= gvt) gy = 0;
    end
  endtask
  task automatic frames(input int n);
    repeat (n * gvt * HT) step();
  endtask
  task automatic do_reset(input bit restart);
    reset = 1;
    step();
    reset = 0;
    if (restart) begin gx = 0; gy = 0; end
  endtask
  task automatic clr();
    p_h = 0; p_v = 0; p_b = 0; p_pv = 0; p_lk = 0;
  endtask
  initial begin
    int cnt0;
    tbl[0] = '{-1, 2, -1, -1, 12'h000, 8, 0, 0, 0, 1, 1};
    tbl[1] = '{ 2, 1, -1, -1, 12'h000, 8, 1, 0, 0, 0, 1};
    tbl[2] = '{ 2, 3, -1, -1, 12'h000, 8, 1, 0, 0, 0, 1};
    tbl[3] = '{-1, 2,  9,  1, 12'h001, 8, 0, 0, 1, 1, 1};
    tbl[4] = '{-1, 2,  2,  6, 12'h0F0, 8, 0, 0, 1, 1, 1};
    tbl[5] = '{-1, 2,  2,  1, 12'hFFF, 8, 0, 0, 0, 1, 1};
    tbl[6] = '{-1, 2, -1, -1, 12'h000, 7, 0, 1, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      do_reset(1);
      clr();
      frames(3);
      chk($sformatf("s%0d_lock", i), locked, 1);
      chk($sformatf("s%0d_clean_cnt", i), err_count, 0);
      chk($sformatf("s%0d_clean_pulses", i), p_h + p_v + p_b, 0);
      cnt0 = err_count;
      clr();
      f_line = tbl[i].fline; f_hlen = tbl[i].fhlen;
      inj_x = tbl[i].ix; inj_y = tbl[i].iy; inj_rgb = tbl[i].irgb; gvt = tbl[i].vt;
      frames(1);
      f_line = -1; f_hlen = HS; inj_x = -1; inj_y = -1; gvt = VT;
      frames(1);
      chk($sformatf("s%0d_locked1", i), locked, tbl[i].lk1);
      frames(1);
      chk($sformatf("s%0d_locked2", i), locked, tbl[i].lk2);
      chk($sformatf("s%0d_h_err", i), p_h, tbl[i].eh);
      chk($sformatf("s%0d_v_err", i), p_v, tbl[i].ev);
      chk($sformatf("s%0d_blank_err", i), p_b, tbl[i].eb);
      chk($sformatf("s%0d_err_count", i), err_count - cnt0, tbl[i].eh + tbl[i].ev + tbl[i].eb);
    end
    do_reset(1);
    frames(3);
    probe_x = 3; probe_y = 2; inj_x = 3; inj_y = 2; inj_rgb = 12'hA00;
    clr();
    frames(2);
    chk("probe_pulses", p_pv, 2);
    chk("probe_rgb", probe_rgb, 12'hA00);
    inj_x = -1; inj_y = -1;
    repeat (2 * HT + 3) step();
    chk("pre_reset_locked", locked, 1);
    do_reset(0);
    chk("reset_outputs", {locked, x_pos, y_pos, active, frame_start, probe_rgb, probe_valid,
        h_err, v_err, blank_err, err_count}, 0);
    clr();
    while (gx != 0 || gy != 0) step();
    frames(1);
    chk("reacq_locked_cycles", p_lk, 0);
    frames(1);
    chk("reacq_locked", locked, 1);
    do_reset(1);
    gvt = VT - 1;
    clr();
    frames(260);
    gvt = VT;
    chk("sat_v_err", p_v, 259);
    chk("sat_err_count", err_count, 255);
    chk("sat_locked_cycles", p_lk, 0);
    do_reset(1);
    rnd_vis = 1;
    for (int f = 0; f < 30; f++) begin
      probe_x = 10'($urandom_range(0, HT - 1));
      probe_y = 10'($urandom_range(0, VT - 1));
      if ($urandom_range(0, 3) == 0) begin
        f_line = $urandom_range(0, VT - 1);
        f_hlen = $urandom_range(1, 3);
      end
      if ($urandom_range(0, 2) == 0) begin
        inj_x = $urandom_range(0, HT - 1);
        inj_y = $urandom_range(0, VT - 1);
        inj_rgb = 12'($urandom);
      end
      frames(1);
      f_line = -1; f_hlen = HS; inj_x = -1; inj_y = -1;
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA timing generator.
- Observes the pixel-clock-domain hsync/vsync/RGB stream, rebuilds the x/y raster position, checks 640x480 timing and blanking, and captures the pixel at a programmable probe coordinate.
- Used in simulation and on-chip self-check to confirm the game display output.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync low width (clocks)
H_TOTAL, 800, clocks per line
V_VIS, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync low width (lines)
V_TOTAL, 525, lines per frame
LOCK_FRAMES, 2, consecutive clean frames needed to lock

Ports:
clk  in  1  pixel clock, one pixel per cycle
reset  in  1  synchronous, active-high reset
hsync  in  1  active-low horizontal sync, clk domain
vsync  in  1  active-low vertical sync, clk domain
red  in  4  pixel red
green  in  4  pixel green
blue  in  4  pixel blue
probe_x  in  10  probe column
probe_y  in  10  probe row
locked  out  1  timing locked
x_pos  out  10  reconstructed column of the registered pixel
y_pos  out  10  reconstructed row of the registered pixel
active  out  1  locked and x_pos<H_VIS and y_pos<V_VIS
frame_start  out  1  one-cycle pulse at locked (0,0)
probe_rgb  out  12  {red,green,blue} captured at the probe point
probe_valid  out  1  one-cycle pulse when probe_rgb updates
h_err  out  1  one-cycle horizontal timing error pulse
v_err  out  1  one-cycle vertical timing error pulse
blank_err  out  1  one-cycle pulse for nonzero RGB in blanking
err_count  out  8  saturating error counter

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high. On reset, every output is 0, state is SEARCH, and all counters are cleared.
- All inputs are registered once. Every detection uses the registered copies, so outputs describe the pixel from 1 cycle earlier.
- Horizontal position:
  - hs_fall is a 1->0 transition of the registered hsync.
  - On hs_fall, x is loaded with H_VIS+H_FP (656).
  - Otherwise x increments and wraps from H_TOTAL-1 to 0.
- Vertical position:
  - On the x wrap, y increments and wraps from V_TOTAL-1 to 0.
  - vs_fall is a 1->0 transition of the registered vsync. On vs_fall, y is loaded with V_VIS+V_FP (490). This load takes priority over the increment.
- Horizontal checks:
  - Clocks between consecutive hs_fall must equal H_TOTAL.
  - The hsync low run, measured at its rising edge, must equal H_SYNC.
  - A mismatch pulses h_err.
  - The period check is skipped until one hs_fall has been seen since reset or since entering SEARCH.
- Vertical checks (19-bit counters):
  - Clocks between consecutive vs_fall must equal V_TOTAL*H_TOTAL (420000).
  - The vsync low run must equal V_SYNC*H_TOTAL (1600).
  - A mismatch pulses v_err. The first-period skip rule is the same as for horizontal.
- Blanking check: when x>=H_VIS or y>=V_VIS and RGB != 0, blank_err pulses. This check runs only when locked.
- FSM:
  - SEARCH: the first vs_fall moves to ACQ with good=0.
  - ACQ:
    - Any h_err or v_err sets good=0.
    - At each vs_fall with no error in the frame, good increments.
    - When good reaches LOCK_FRAMES, move to LOCKED. locked rises on the cycle after that vs_fall.
  - LOCKED:
    - h_err or v_err moves to SEARCH. locked falls the next cycle.
    - blank_err does not drop lock.
- err_count:
  - Increments by 1 in any cycle where any error pulse is asserted. Simultaneous errors in one cycle count once.
  - Saturates at 255. Cleared only by reset.
- frame_start pulses when locked and the updated x=0, y=0.
- Probe capture:
  - Triggers when active and x==probe_x and y==probe_y.
  - probe_rgb takes the registered {red,green,blue}; probe_valid pulses for 1 cycle.
  - probe_rgb holds between captures. Probe inputs are sampled every cycle.
- Reset mid-frame discards all history. Reacquisition requires the full SEARCH->ACQ sequence.

Test Plan:
1. Ideal 640x480 stream with LOCK_FRAMES=2 -> locked=1 one cycle after the 3rd vsync fall; the first frame_start follows 35 lines later; no error pulses; err_count=0.
2. Locked; red=4'hA, green=0, blue=0 only at pixel (100,50); probe=(100,50) -> probe_rgb=12'hA00, one probe_valid pulse per frame, x_pos=100/y_pos=50 in that cycle.
3. Locked; one line with hsync low for 95 clocks -> h_err at the hsync rise; locked=0 next cycle; err_count=1; relock after 3 more vsync falls.
4. Locked; blue=4'h1 at x=700 -> single blank_err; locked stays 1; err_count increments by 1.
5. Assert reset mid-frame while locked -> all outputs 0 on the next cycle; locked stays 0 until a full reacquisition.
6. Force more than 255 errors (vsync period 524 lines, repeated) -> err_count holds at 255; v_err pulses each frame.
